// File: rtl/mimi_wb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : mimi_wb_bridge_if
// Brief    : Bundles the minimax data-port and Wishbone master signals of the bridge.
// Revision : 1.0  initial release
// ============================================================================
interface mimi_wb_bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_rreq;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    logic        err_clr;
    logic        bus_err;

    // Bridge side
    modport master (
        input  cpu_addr, cpu_wdata, cpu_wmask, cpu_rreq, err_clr,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cpu_rdata, cpu_stall, bus_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    // CPU + Wishbone slave side
    modport slave (
        output cpu_addr, cpu_wdata, cpu_wmask, cpu_rreq, err_clr,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cpu_rdata, cpu_stall, bus_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/mimi_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mimi_wb_bridge
// Brief    : Minimax data port to Wishbone classic master, with timeout abort.
// Revision : 1.0  initial release
// ============================================================================
module mimi_wb_bridge #(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  wire              clk,
    input  wire              rst_n,
    mimi_wb_bridge_if.master bus
);
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_cyc;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rdata;
    logic        r_bus_err;

    logic w_store;
    logic w_req;
    logic w_stall;
    logic w_unused_addr_bits;

    assign w_store            = |bus.cpu_wmask;
    assign w_req              = w_store | bus.cpu_rreq;
    assign w_unused_addr_bits = ^bus.cpu_addr[1:0];

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_req;
            S_WAIT:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_rdata   <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            // Clear first so a same-cycle error set below takes precedence.
            if (bus.err_clr) begin
                r_bus_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr   <= {bus.cpu_addr[31:2], 2'b00};
                        r_dat   <= bus.cpu_wdata;
                        r_we    <= w_store;
                        r_sel   <= w_store ? bus.cpu_wmask : 4'hF;
                        r_cyc   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.wbm_err_i || (!bus.wbm_ack_i && r_cnt == c_TMO_LAST)) begin
                        r_bus_err <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= ERR_RDATA;
                        end
                        r_cyc   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (bus.wbm_ack_i) begin
                        if (!r_we) begin
                            r_rdata <= bus.wbm_dat_i;
                        end
                        r_cyc   <= 1'b0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_stall = rst_n & w_stall;
    assign bus.cpu_rdata = r_rdata;
    assign bus.bus_err   = r_bus_err;
    assign bus.wbm_cyc_o = r_cyc;
    assign bus.wbm_stb_o = r_cyc;
    assign bus.wbm_we_o  = r_we;
    assign bus.wbm_sel_o = r_sel;
    assign bus.wbm_adr_o = r_adr;
    assign bus.wbm_dat_o = r_dat;
endmodule
`default_nettype wire

// File: tb/tb_mimi_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mimi_wb_bridge
// Brief    : Self-checking bench for mimi_wb_bridge against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mimi_wb_bridge;
    localparam int          c_TIMEOUT   = 4;
    localparam logic [31:0] c_ERR_RDATA = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    mimi_wb_bridge_if bus ();

    mimi_wb_bridge #(
        .TIMEOUT   (c_TIMEOUT),
        .ERR_RDATA (c_ERR_RDATA)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One CPU access (or an idle cycle when no request) plus the slave's reply.
    // term_k: WAIT cycle (1-based) in which the slave terminates; 0 = never.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic rreq,
                           input int term_k, input logic term_err, input logic ack_too,
                           input logic [31:0] rd, input logic clr_req, input logic clr_term);
        logic is_store, is_req, pset, pclr, done, term, timed, ok;
        int   k, exp_k;
        is_store = |wmask;
        is_req   = is_store | rreq;
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_wmask = wmask;
        bus.cpu_rreq  = rreq;
        bus.err_clr   = clr_req;
        pset = 1'b0;
        pclr = clr_req;
        #1 chk("stall_req", 32'(bus.cpu_stall), 32'(is_req));
        k    = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            exp_err = pset ? 1'b1 : (pclr ? 1'b0 : exp_err);
            bus.cpu_rreq  = 1'b0;
            bus.cpu_wmask = 4'h0;
            bus.err_clr   = 1'b0;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            pset = 1'b0;
            pclr = 1'b0;
            if (bus.wbm_cyc_o) begin
                k++;
                chk("stb", 32'(bus.wbm_stb_o), 32'd1);
                chk("stall_wait", 32'(bus.cpu_stall), 32'd1);
                chk("adr", bus.wbm_adr_o, {addr[31:2], 2'b00});
                chk("sel", 32'(bus.wbm_sel_o), 32'(is_store ? wmask : 4'hF));
                chk("we", 32'(bus.wbm_we_o), 32'(is_store));
                chk("dat_o", bus.wbm_dat_o, wdata);
                term  = (k == term_k);
                timed = !term && (k == c_TIMEOUT);
                bus.wbm_ack_i = term && (!term_err || ack_too);
                bus.wbm_err_i = term && term_err;
                bus.wbm_dat_i = term ? rd : $urandom;
                bus.err_clr   = (term && clr_term) || ($urandom_range(0, 7) == 0);
                pclr = bus.err_clr;
                pset = (term && term_err) || timed;
            end else begin
                done = 1'b1;
            end
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        if (!done) chk("wait_bound", 32'd0, 32'd1);
        ok    = (term_k >= 1) && (term_k <= c_TIMEOUT);
        exp_k = !is_req ? 0 : (ok ? term_k : c_TIMEOUT);
        if (is_req && !is_store) exp_rdata = (ok && !term_err) ? rd : c_ERR_RDATA;
        #1;
        chk("wait_cycles", 32'(k), 32'(exp_k));
        chk("cyc_after", 32'(bus.wbm_cyc_o), 32'd0);
        chk("stall_resp", 32'(bus.cpu_stall), 32'd0);
        chk("rdata", bus.cpu_rdata, exp_rdata);
        chk("bus_err", 32'(bus.bus_err), 32'(exp_err));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"}, 32'(bus.wbm_cyc_o), 32'd0);
        chk({tag, "_stb"}, 32'(bus.wbm_stb_o), 32'd0);
        chk({tag, "_we"}, 32'(bus.wbm_we_o), 32'd0);
        chk({tag, "_sel"}, 32'(bus.wbm_sel_o), 32'd0);
        chk({tag, "_adr"}, bus.wbm_adr_o, 32'd0);
        chk({tag, "_dat"}, bus.wbm_dat_o, 32'd0);
        chk({tag, "_rdata"}, bus.cpu_rdata, 32'd0);
        chk({tag, "_err"}, 32'(bus.bus_err), 32'd0);
        chk({tag, "_stall"}, 32'(bus.cpu_stall), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        rst_n         = 1'b0;
        bus.cpu_addr  = 32'h0000_1000;
        bus.cpu_wdata = 32'd0;
        bus.cpu_wmask = 4'h0;
        bus.cpu_rreq  = 1'b1;
        bus.err_clr   = 1'b0;
        bus.wbm_dat_i = 32'd0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        #1 chk_reset_outputs("por");
        @(negedge clk);
        bus.cpu_rreq = 1'b0;
        rst_n = 1'b1;

        // Zero-wait load, sub-word address
        run_txn(32'h0000_0206, 32'h0, 4'h0, 1'b1, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Store acked in the 4th WAIT cycle; read data must be untouched
        run_txn(32'h0000_0300, 32'h1234_5678, 4'b0011, 1'b0, 4, 1'b0, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0);
        // Unanswered load times out
        run_txn(32'h0000_0400, 32'h0, 4'h0, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Idle cycle with err_clr pulse
        run_txn(32'h0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        // ack+err together, err_clr in the same cycle: set wins
        run_txn(32'h0000_0500, 32'h0, 4'h0, 1'b1, 2, 1'b1, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1);
        run_txn(32'h0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        // Load and store together: store only
        run_txn(32'h0000_0604, 32'hCAFE_F00D, 4'hF, 1'b1, 1, 1'b0, 1'b0, 32'h7777_7777, 1'b0, 1'b0);
        run_txn(32'h0, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] wm;
            wm = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_txn($urandom, $urandom, wm, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        // Reset asserted in the 2nd WAIT cycle, with a late ack around it
        @(negedge clk);
        bus.cpu_addr  = 32'h0000_0808;
        bus.cpu_wdata = 32'h1111_2222;
        bus.cpu_rreq  = 1'b1;
        @(negedge clk);
        bus.cpu_rreq = 1'b0;
        @(negedge clk);
        chk("rst_pre_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        rst_n         = 1'b0;
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h9999_9999;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.wbm_ack_i = 1'b0;
        chk_reset_outputs("post_rst");
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        run_txn(32'h0000_0A00, 32'h0, 4'h0, 1'b1, 2, 1'b0, 1'b0, 32'h4242_4242, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
